// File: rtl/ula_request_controller.sv
// Initiator-side controller for the ULA operation interface: accepts one tagged request,
// drives the ULA with registered operands, waits for completion or timeout and returns a tagged response.
module ula_request_controller #(
  parameter int unsigned TAG_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned TIMEOUT       = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [7:0]       req_a,
  input  logic [7:0]       req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       ula_operation,
  output logic [7:0]       operand1,
  output logic [7:0]       operand2,
  input  logic [7:0]       result,
  input  logic [3:0]       flags,
  input  logic             ula_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout,
  output logic             busy
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, WAIT, RESP} state_t;

  state_t           state, state_n;
  logic [SW-1:0]    settle_cnt, settle_cnt_n;
  logic [WW-1:0]    wait_cnt, wait_cnt_n;
  logic [3:0]       op_n;
  logic [7:0]       a_n, b_n, res_n;
  logic [3:0]       flg_n;
  logic [TAG_W-1:0] tag_n;
  logic             to_n;
  logic             op_valid;

  assign op_valid  = (req_op != 4'b0000) && (req_op != 4'b1101);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      settle_cnt    <= '0;
      wait_cnt      <= '0;
      ula_operation <= '0;
      operand1      <= '0;
      operand2      <= '0;
      rsp_result    <= '0;
      rsp_flags     <= '0;
      rsp_tag       <= '0;
      rsp_timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      settle_cnt    <= settle_cnt_n;
      wait_cnt      <= wait_cnt_n;
      ula_operation <= op_n;
      operand1      <= a_n;
      operand2      <= b_n;
      rsp_result    <= res_n;
      rsp_flags     <= flg_n;
      rsp_tag       <= tag_n;
      rsp_timeout   <= to_n;
    end
  end

  always_comb begin
    state_n      = state;
    settle_cnt_n = settle_cnt;
    wait_cnt_n   = wait_cnt;
    op_n         = ula_operation;
    a_n          = operand1;
    b_n          = operand2;
    res_n        = rsp_result;
    flg_n        = rsp_flags;
    tag_n        = rsp_tag;
    to_n         = rsp_timeout;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tag_n = req_tag;
          if (op_valid) begin
            op_n         = req_op;
            a_n          = req_a;
            b_n          = req_b;
            settle_cnt_n = SW'(SETTLE_CYCLES - 1);
            state_n      = SETTLE;
          end else begin
            res_n   = '0;
            flg_n   = '0;
            to_n    = 1'b0;
            state_n = RESP;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          wait_cnt_n = '0;
          state_n    = WAIT;
        end else begin
          settle_cnt_n = settle_cnt - 1'b1;
        end
      end
      WAIT: begin
        if (ula_ready) begin
          res_n   = result;
          flg_n   = flags;
          to_n    = 1'b0;
          state_n = RESP;
        end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
          res_n   = '0;
          flg_n   = '0;
          to_n    = 1'b1;
          state_n = RESP;
        end else begin
          wait_cnt_n = wait_cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          op_n    = '0;
          a_n     = '0;
          b_n     = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
